// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared sizing and load-value helpers for the hazard scoreboard
package hazard_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int REG_W_DEF    = 4;
    localparam int NUM_SRC_DEF  = 2;
    localparam int WB_DEPTH_DEF = 2;
    localparam int LAT_W_DEF    = 3;
    localparam int SC_W_DEF     = 16;

    // Counter must hold the longest load value: WB_DEPTH plus the largest extra latency.
    function automatic int cnt_width(input int wb_depth, input int lat_w);
        return $clog2(wb_depth + (2 ** lat_w) + 1);
    endfunction

    // Cycles a dependent must wait after the writer issues.
    function automatic int load_value(input bit forward_en, input bit mem_r,
                                      input int xlat, input int wb_depth);
        if (forward_en)
            return xlat + (mem_r ? 1 : 0);
        else
            return wb_depth + xlat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// rtl/hazard_scoreboard_sb_counter.sv - per-register countdown with load-max and hold
module sb_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    logic [CW-1:0] dec;
    logic [CW-1:0] next_cnt;

    always_comb begin
        dec      = (cnt != '0) ? cnt - CW'(1) : '0;
        next_cnt = dec;
        // Keep the larger value so a short younger writer cannot release an older long one.
        if (load && (load_val > dec))
            next_cnt = load_val;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (!hold)
            cnt <= next_cnt;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage countdown scoreboard driving freeze/bubble and stall statistics
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int CW       = cnt_width(WB_DEPTH_DEF, LAT_W_DEF),
    parameter int SC_W     = SC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*REG_W-1:0] src_idx,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic                     id_valid,
    input  logic                     id_wb_en,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_mem_r,
    input  logic [LAT_W-1:0]         id_xlat,
    input  logic                     forward_en,
    input  logic                     stall_in,
    input  logic                     flush,
    output logic                     hazard_detected,
    output logic [NUM_SRC-1:0]       hazard_src,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [SC_W-1:0]          stall_count
);

    localparam int IDX_N = 2 ** REG_W;

    logic              issue;
    logic [CW-1:0]     load_val;
    logic [IDX_N-1:0]  busy_pad;

    // Indices beyond NUM_REGS read as never busy.
    assign busy_pad = IDX_N'(busy_vec);

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_W-1:0] idx;
        assign idx           = src_idx[k*REG_W +: REG_W];
        assign hazard_src[k] = src_valid[k] & busy_pad[idx];
    end

    assign hazard_detected = id_valid & ~flush & (|hazard_src);
    assign issue           = id_valid & id_wb_en & ~hazard_detected & ~stall_in & ~flush;
    assign load_val        = CW'(load_value(forward_en, id_mem_r, int'(id_xlat), WB_DEPTH));

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [CW-1:0] cnt;
        sb_counter #(.CW(CW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .hold     (stall_in),
            .load     (issue && (id_dest == REG_W'(r))),
            .load_val (load_val),
            .cnt      (cnt),
            .busy     (busy_vec[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (hazard_detected && !stall_in && (stall_count != '1))
            stall_count <= stall_count + SC_W'(1);
    end

endmodule
